example_mac_accum: RTL and testbench

//  Downstream consumer of the signed 6x14 product multiplier (20-bit signed product).

---
 rtl/example_mac_accum.sv | 125 ++++++++++++
 tb/tb_example_mac_accum.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/example_mac_accum.sv
// example_mac_accum: sums NUM_TERMS signed products, then arithmetic-shifts and
// saturates the sum onto a valid/ready result port. Rev 1.0
`default_nettype none

module example_mac_accum #(
   parameter int PROD_WIDTH = 20,
   parameter int NUM_TERMS  = 8,
   parameter int ACC_WIDTH  = 23,
   parameter int OUT_WIDTH  = 16,
   parameter int OUT_SHIFT  = 4
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic [PROD_WIDTH-1:0] prod_tdata,
   input  logic                  prod_tvalid,
   output logic                  prod_tready,
   output logic [OUT_WIDTH-1:0]  res_tdata,
   output logic                  res_tvalid,
   input  logic                  res_tready,
   output logic                  res_sat
);

   localparam int CNT_W = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;
   localparam int CMP_W = ((ACC_WIDTH > OUT_WIDTH) ? ACC_WIDTH : OUT_WIDTH) + 1;

   localparam logic signed [CMP_W-1:0] c_max = {{(CMP_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [CMP_W-1:0] c_min = {{(CMP_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

   typedef enum logic [0:0] {
      ST_ACC = 1'b0,
      ST_OUT = 1'b1
   } state_t;

   state_t                       r_state, w_state_nxt;
   logic signed [ACC_WIDTH-1:0]  r_acc, w_acc_nxt;
   logic [CNT_W-1:0]             r_cnt, w_cnt_nxt;
   logic                         w_ready_nxt, w_valid_nxt, w_sat_nxt;
   logic [OUT_WIDTH-1:0]         w_data_nxt;

   logic signed [ACC_WIDTH-1:0]  w_prod_ext, w_sum, w_shift;
   logic signed [CMP_W-1:0]      w_wide;
   logic [OUT_WIDTH-1:0]         w_sat_data;
   logic                         w_sat_flag;
   logic                         w_accept, w_last;

   assign w_prod_ext = ACC_WIDTH'($signed(prod_tdata));
   assign w_sum      = r_acc + w_prod_ext;
   assign w_shift    = w_sum >>> OUT_SHIFT;
   assign w_wide     = CMP_W'(w_shift);
   assign w_accept   = prod_tvalid & prod_tready;
   assign w_last     = (NUM_TERMS == 1) || (r_cnt == CNT_W'(NUM_TERMS - 1));

   // Compare at a width wide enough for both bounds so the clamp is exact.
   always_comb begin
      w_sat_flag = 1'b0;
      w_sat_data = w_wide[OUT_WIDTH-1:0];
      if (w_wide > c_max) begin
         w_sat_flag = 1'b1;
         w_sat_data = c_max[OUT_WIDTH-1:0];
      end else if (w_wide < c_min) begin
         w_sat_flag = 1'b1;
         w_sat_data = c_min[OUT_WIDTH-1:0];
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_acc_nxt   = r_acc;
      w_cnt_nxt   = r_cnt;
      w_ready_nxt = prod_tready;
      w_valid_nxt = res_tvalid;
      w_data_nxt  = res_tdata;
      w_sat_nxt   = res_sat;
      case (r_state)
         ST_ACC: begin
            w_ready_nxt = 1'b1;
            if (w_accept) begin
               if (w_last) begin
                  w_data_nxt  = w_sat_data;
                  w_sat_nxt   = w_sat_flag;
                  w_valid_nxt = 1'b1;
                  w_ready_nxt = 1'b0;
                  w_acc_nxt   = '0;
                  w_cnt_nxt   = '0;
                  w_state_nxt = ST_OUT;
               end else begin
                  w_acc_nxt = w_sum;
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
         end
         ST_OUT: begin
            if (res_tvalid && res_tready) begin
               w_valid_nxt = 1'b0;
               w_ready_nxt = 1'b1;
               w_state_nxt = ST_ACC;
            end
         end
         default: w_state_nxt = ST_ACC;
      endcase
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_state     <= ST_ACC;
         r_acc       <= '0;
         r_cnt       <= '0;
         prod_tready <= 1'b0;
         res_tvalid  <= 1'b0;
         res_tdata   <= '0;
         res_sat     <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_acc       <= w_acc_nxt;
         r_cnt       <= w_cnt_nxt;
         prod_tready <= w_ready_nxt;
         res_tvalid  <= w_valid_nxt;
         res_tdata   <= w_data_nxt;
         res_sat     <= w_sat_nxt;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_example_mac_accum.sv
// tb_example_mac_accum: directed self-checking bench for example_mac_accum. Rev 1.0
`default_nettype none

module tb_example_mac_accum;

   logic        ap_clk = 1'b0;
   logic        ap_rst_n = 1'b0;
   logic [19:0] prod_tdata = '0;
   logic        prod_tvalid = 1'b0;
   logic        prod_tready;
   logic [15:0] res_tdata;
   logic        res_tvalid;
   logic        res_tready = 1'b0;
   logic        res_sat;

   int n_cmp = 0;
   int n_err = 0;

   example_mac_accum #(
      .PROD_WIDTH(20), .NUM_TERMS(8), .ACC_WIDTH(23), .OUT_WIDTH(16), .OUT_SHIFT(4)
   ) dut (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
      .prod_tdata(prod_tdata), .prod_tvalid(prod_tvalid), .prod_tready(prod_tready),
      .res_tdata(res_tdata), .res_tvalid(res_tvalid), .res_tready(res_tready),
      .res_sat(res_sat)
   );

   always #5 ap_clk = ~ap_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge following the accepting posedge.
   task automatic send(input logic [19:0] v);
      bit done = 0;
      prod_tdata  = v;
      prod_tvalid = 1'b1;
      for (int i = 0; i < 50 && !done; i++) begin
         if (prod_tready) done = 1;
         @(posedge ap_clk);
         @(negedge ap_clk);
      end
      prod_tvalid = 1'b0;
      if (!done) chk("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic send_group(input logic [19:0] v);
      for (int i = 0; i < 8; i++) send(v);
   endtask

   // Wait for a result, check it, then complete the handshake.
   task automatic take(input string tag, input logic [15:0] exp_d, input logic exp_s);
      bit seen = 0;
      for (int i = 0; i < 50 && !seen; i++) begin
         if (res_tvalid) seen = 1;
         else @(negedge ap_clk);
      end
      chk({tag, "_valid"}, 32'(res_tvalid), 32'd1);
      chk({tag, "_data"}, 32'(res_tdata), 32'(exp_d));
      chk({tag, "_sat"}, 32'(res_sat), 32'(exp_s));
      res_tready = 1'b1;
      @(posedge ap_clk);
      @(negedge ap_clk);
      res_tready = 1'b0;
      chk({tag, "_drop"}, 32'(res_tvalid), 32'd0);
      chk({tag, "_rdy"}, 32'(prod_tready), 32'd1);
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge ap_clk);
      chk("rst_rdy", 32'(prod_tready), 32'd0);
      chk("rst_valid", 32'(res_tvalid), 32'd0);
      chk("rst_data", 32'(res_tdata), 32'd0);
      chk("rst_sat", 32'(res_sat), 32'd0);
      ap_rst_n = 1'b1;
      #1 chk("rel_rdy_low", 32'(prod_tready), 32'd0);
      @(negedge ap_clk);
      chk("rel_rdy_high", 32'(prod_tready), 32'd1);

      // 1: 8 x 1000 -> 8000 >>> 4 = 500, result one cycle after 8th accept
      res_tready = 1'b1;
      for (int i = 0; i < 7; i++) send(20'd1000);
      chk("t1_not_early", 32'(res_tvalid), 32'd0);
      send(20'd1000);
      chk("t1_latency", 32'(res_tvalid), 32'd1);
      chk("t1_data", 32'(res_tdata), 32'd500);
      chk("t1_sat", 32'(res_sat), 32'd0);
      chk("t1_rdy_low", 32'(prod_tready), 32'd0);
      @(negedge ap_clk);
      chk("t1_drop", 32'(res_tvalid), 32'd0);
      chk("t1_rdy_back", 32'(prod_tready), 32'd1);
      res_tready = 1'b0;

      // 2: saturation both directions
      send_group(20'h7FFFF);
      take("t2_pos", 16'h7FFF, 1'b1);
      send_group(20'h80000);
      take("t2_neg", 16'h8000, 1'b1);

      // 3: -8 >>> 4 floors to -1
      send_group(20'hFFFFF);
      take("t3", 16'hFFFF, 1'b0);

      // 4: backpressure holds result and blocks products
      send_group(20'd100);
      prod_tdata  = 20'd9999;
      prod_tvalid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge ap_clk);
         chk("t4_hold_data", 32'(res_tdata), 32'd50);
         chk("t4_hold_valid", 32'(res_tvalid), 32'd1);
         chk("t4_hold_rdy", 32'(prod_tready), 32'd0);
      end
      prod_tvalid = 1'b0;
      take("t4_res", 16'd50, 1'b0);
      send_group(20'd200);
      take("t4_next", 16'd100, 1'b0);

      // 5: 1..8 with random valid gaps -> 36 >>> 4 = 2
      for (int i = 1; i <= 8; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge ap_clk);
         send(20'(i));
      end
      take("t5", 16'd2, 1'b0);

      // 6: reset mid-group discards partial sum
      for (int i = 0; i < 3; i++) send(20'd1600);
      ap_rst_n = 1'b0;
      #1;
      chk("t6_rst_rdy", 32'(prod_tready), 32'd0);
      chk("t6_rst_valid", 32'(res_tvalid), 32'd0);
      chk("t6_rst_data", 32'(res_tdata), 32'd0);
      chk("t6_rst_sat", 32'(res_sat), 32'd0);
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      @(negedge ap_clk);
      send_group(20'd160);
      take("t6", 16'd80, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
